// File: rtl/spram_banked_rw_if.sv
// Request/response bundle for spram_banked_rw: a write port and a read port
// that share one physical SPRAM port behind the arbiter.
interface spram_banked_rw_if #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 16384
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int MW = (RAM_WIDTH + 3) / 4;

    logic                 wr_en;
    logic                 wr_ready;
    logic [AW-1:0]        wr_addr;
    logic [RAM_WIDTH-1:0] wr_data;
    logic [MW-1:0]        wr_mask;

    logic                 rd_req;
    logic                 rd_ready;
    logic [AW-1:0]        rd_addr;
    logic [RAM_WIDTH-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_mask, rd_req, rd_addr,
        input  wr_ready, rd_ready, rd_data, rd_valid, rd_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_mask, rd_req, rd_addr,
        output wr_ready, rd_ready, rd_data, rd_valid, rd_err
    );
endinterface

// File: rtl/spram_banked_rw.sv
// Banked, lane-tiled SPRAM with separate write/read request ports sharing the
// single macro port through a bounded-starvation arbiter and a one-entry
// deferred-read buffer.

// Behavioural model of one SB_SPRAM256KA tile (16 bits x 16384 words), same
// port list and timing as the iCE40UP primitive: masked write or registered
// read at the rising edge while selected and powered.
module spram_banked_rw_tile (
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        CLOCK,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);
    logic [15:0] mem [16384];

    // Macro array access: nibble-masked write, otherwise registered read.
    always_ff @(posedge CLOCK) begin
        if (CHIPSELECT && !STANDBY && !SLEEP && POWEROFF) begin
            if (WREN) begin
                for (int j = 0; j < 4; j++) begin
                    if (MASKWREN[j]) begin
                        mem[ADDRESS][4*j +: 4] <= DATAIN[4*j +: 4];
                    end
                end
            end else begin
                DATAOUT <= mem[ADDRESS];
            end
        end
    end
endmodule

module spram_banked_rw #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 16384,
    parameter int MAX_DEFER = 4
) (
    input  logic            clk,
    input  logic            rst,
    spram_banked_rw_if.slave bus
);
    localparam int AW    = $clog2(RAM_DEPTH);
    localparam int MW    = (RAM_WIDTH + 3) / 4;
    localparam int LANES = (RAM_WIDTH + 15) / 16;
    localparam int BANKS = (RAM_DEPTH + 16383) / 16384;
    localparam int DW    = LANES * 16;
    // Address padded to at least 15 bits so the bank field always exists.
    localparam int AWP   = (AW > 14) ? AW : 15;
    localparam int BW    = AWP - 14;

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    defer_cnt;
    logic [7:0]    defer_next;
    logic [AW-1:0] pend_addr;

    logic          issue_wr;
    logic          issue_rd;
    logic          capture_pend;
    logic [AW-1:0] rd_sel_addr;

    logic [AW-1:0]  acc_addr;
    logic [AWP-1:0] addr_pad;
    logic [13:0]    acc_row;
    logic [BW-1:0]  acc_bank;
    logic           acc_in_range;
    logic           acc_any;
    logic [DW-1:0]  data_pad;
    logic [4*LANES-1:0] mask_pad;

    logic [BANKS-1:0][DW-1:0] bank_dout;
    logic [DW-1:0]  mux_data;

    logic           iss_valid;
    logic           iss_err;
    logic [BW-1:0]  iss_bank;

    // Arbiter state, defer counter and the captured address of a deferred read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            defer_cnt <= '0;
            pend_addr <= '0;
        end else begin
            state     <= state_next;
            defer_cnt <= defer_next;
            if (capture_pend) begin
                pend_addr <= bus.rd_addr;
            end
        end
    end

    // Next-state: a colliding read waits at most MAX_DEFER write-won cycles.
    always_comb begin
        state_next = state;
        defer_next = defer_cnt;
        case (state)
            IDLE: begin
                if (bus.wr_en && bus.rd_req) begin
                    state_next = (MAX_DEFER == 1) ? FORCE : PEND;
                    defer_next = 8'd1;
                end
            end
            PEND: begin
                if (!bus.wr_en) begin
                    state_next = IDLE;
                    defer_next = '0;
                end else begin
                    defer_next = defer_cnt + 8'd1;
                    if (defer_cnt + 8'd1 >= 8'(MAX_DEFER)) begin
                        state_next = FORCE;
                    end
                end
            end
            FORCE: begin
                state_next = IDLE;
                defer_next = '0;
            end
            default: begin
                state_next = IDLE;
                defer_next = '0;
            end
        endcase
    end

    // Handshake outputs and the choice of which request owns the macro port.
    always_comb begin
        bus.wr_ready = (state != FORCE);
        bus.rd_ready = (state == IDLE);
        issue_wr     = 1'b0;
        issue_rd     = 1'b0;
        capture_pend = 1'b0;
        rd_sel_addr  = bus.rd_addr;
        case (state)
            IDLE: begin
                issue_wr     = bus.wr_en;
                issue_rd     = bus.rd_req && !bus.wr_en;
                capture_pend = bus.rd_req && bus.wr_en;
            end
            PEND: begin
                issue_wr    = bus.wr_en;
                issue_rd    = !bus.wr_en;
                rd_sel_addr = pend_addr;
            end
            FORCE: begin
                issue_rd    = 1'b1;
                rd_sel_addr = pend_addr;
            end
            default: begin
                issue_wr = 1'b0;
            end
        endcase
    end

    // Address split into bank/row, range check, and zero-padded data/mask.
    always_comb begin
        acc_addr              = issue_wr ? bus.wr_addr : rd_sel_addr;
        addr_pad              = '0;
        addr_pad[AW-1:0]      = acc_addr;
        acc_row               = addr_pad[13:0];
        acc_bank              = addr_pad[AWP-1:14];
        acc_in_range          = ({1'b0, acc_addr} < (AW+1)'(RAM_DEPTH));
        acc_any               = (issue_wr || issue_rd) && acc_in_range;
        data_pad              = '0;
        data_pad[RAM_WIDTH-1:0] = bus.wr_data;
        mask_pad              = '0;
        mask_pad[MW-1:0]      = bus.wr_mask;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic cs;
        assign cs = acc_any && (acc_bank == BW'(b));
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            spram_banked_rw_tile u_tile (
                .ADDRESS    (acc_row),
                .DATAIN     (data_pad[16*l +: 16]),
                .MASKWREN   (mask_pad[4*l +: 4]),
                .WREN       (issue_wr),
                .CHIPSELECT (cs),
                .CLOCK      (clk),
                .STANDBY    (1'b0),
                .SLEEP      (1'b0),
                .POWEROFF   (1'b1),
                .DATAOUT    (bank_dout[b][16*l +: 16])
            );
        end
    end

    // Pick DATAOUT of the bank that was read in the previous cycle.
    always_comb begin
        mux_data = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (iss_bank == BW'(b)) begin
                mux_data = bank_dout[b];
            end
        end
    end

    // Two-stage read pipeline; reset squashes anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid    <= 1'b0;
            iss_err      <= 1'b0;
            iss_bank     <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            iss_valid    <= issue_rd;
            iss_err      <= issue_rd && !acc_in_range;
            iss_bank     <= acc_bank;
            bus.rd_valid <= iss_valid;
            bus.rd_err   <= iss_valid && iss_err;
            bus.rd_data  <= (iss_valid && !iss_err) ? mux_data[RAM_WIDTH-1:0] : '0;
        end
    end
endmodule

// File: doc/spram_banked_rw.md
# spram_banked_rw

Parametrised single-clock memory built from tiled SB_SPRAM256KA primitives (16 bits x 16384 words each), with independent write and read request ports arbitrated onto the single physical port. Width is tiled in 16-bit lanes and depth in 16K-word banks. A one-entry deferred-read buffer and a bounded-starvation arbiter let a writer and a reader share the macro without dropping requests. It replaces fixed single-macro wrappers wherever buffers exceed 16 bits or 16K words, such as weight and spike stores.

## Interface
- RAM_WIDTH, 16: data width in bits, 1..64; LANES = ceil(RAM_WIDTH/16) macros per bank.
- RAM_DEPTH, 16384: words, 2..65536; BANKS = ceil(RAM_DEPTH/16384).
- MAX_DEFER, 4: maximum consecutive write-won cycles a pending read waits, 1..255.
- Derived: AW = clogb2(RAM_DEPTH-1); MW = ceil(RAM_WIDTH/4).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset; memory contents unaffected.
- wr_en  in  1  write request; held until accepted.
- wr_ready  out  1  write accepted on edge where wr_en & wr_ready.
- wr_addr  in  AW  write word address.
- wr_data  in  RAM_WIDTH  write data.
- wr_mask  in  MW  per-nibble write enable; bit i covers data bits [4i+3:4i].
- rd_req  in  1  read request.
- rd_ready  out  1  read accepted on edge where rd_req & rd_ready.
- rd_addr  in  AW  read word address.
- rd_data  out  RAM_WIDTH  registered read data.
- rd_valid  out  1  rd_data valid for exactly this cycle.
- rd_err  out  1  qualifies rd_valid; read address was >= RAM_DEPTH.

## Operation
- Address decode: bank = addr[AW-1:14] (0 when AW <= 14); row = addr[13:0], zero-extended. Data is zero-padded to LANES*16. Mask nibble for lane l, position j maps to MASKWREN[j] of that macro.
- Each cycle, at most one macro bank is accessed, with either the write or the read address. Unselected banks have CHIPSELECT = 0. STANDBY = 0, SLEEP = 0, and POWEROFF = 1 on all banks.
- Arbiter FSM (registered):
  - IDLE: no pending read; rd_ready = 1, wr_ready = 1.
    - Read and write both accepted in the same cycle: the write is issued, the read is captured into the pending buffer, defer_cnt is set to 1, and the FSM goes to PEND.
    - Read accepted with no write: the read is issued directly and the FSM stays in IDLE.
  - PEND: rd_ready = 0, wr_ready = 1.
    - wr_en = 0: the pending read is issued and the FSM goes to IDLE.
    - wr_en = 1: the write is issued and defer_cnt increments. When defer_cnt reaches MAX_DEFER, the FSM goes to FORCE.
  - FORCE: rd_ready = 0, wr_ready = 0. The pending read is issued, wr_en is ignored (the writer holds), and the FSM goes to IDLE.
- Ordering: a read deferred behind a write to the same address returns the newly written data. A read issued in an earlier cycle than a write returns the old data.
- Out-of-range: a write with wr_addr >= RAM_DEPTH is accepted and discarded. A read with rd_addr >= RAM_DEPTH is accepted, performs no macro access, and returns rd_data = 0 with rd_err = 1.
- Read pipeline: the bank index and the err bit are registered alongside the issue. The output mux selects DATAOUT of the issued bank, and the result is registered into rd_data.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, rd_err = 0, rd_ready = 1, wr_ready = 1; FSM = IDLE; defer_cnt = 0.
- Read latency: a read issued in cycle n has rd_valid = 1 in cycle n+2. Undeferred reads sustain one per cycle.
- Deferred read: the extra latency equals the number of write-won cycles, at most MAX_DEFER. A FORCE cycle adds exactly one cycle of wr_ready = 0.
- Write: the macro updates at the accepting edge. A read issued in the following cycle sees the new data.
- rst asserted mid-operation: the pending read is dropped and in-flight reads are squashed. rd_valid = 0 in the cycle after the rst edge. Writes accepted before the rst edge are kept.
- rd_valid is a single-cycle pulse with no backpressure; the consumer must always accept.

## Test plan
- Reset, then write 0xA5A5 to address 3 with mask = all ones, then read address 3 → rd_valid two cycles after acceptance with rd_data = 0xA5A5 and rd_err = 0.
- RAM_WIDTH = 36, RAM_DEPTH = 40000: write 0xF_1234_5678 to address 20000 (bank 1), then read it → rd_data = 0xF_1234_5678. Address 20000 - 16384 in bank 0 is unchanged.
- Simultaneous write of 0x0055 to address 7 and read of address 7 → read deferred, rd_ready = 0 for one cycle, returned value is 0x0055.
- Continuous wr_en with one pending read, MAX_DEFER = 4 → exactly one wr_ready = 0 cycle after 4 write-won cycles, then rd_valid two cycles later, and no write lost (verify by readback).
- Read of address RAM_DEPTH → rd_valid = 1, rd_err = 1, rd_data = 0. A write to that address leaves every in-range location unchanged.
- rst asserted one cycle after a read is accepted → no rd_valid pulse. Outputs match reset values, and a subsequent read returns the pre-reset contents.
